// File: rtl/sevenseg_capture_if.sv
// Seven-segment bus as seen by a capture monitor: multiplexed segment/anode
// lines in, recovered digits and status out.
interface sevenseg_capture_if;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit_valid;
  logic       frame_valid;
  logic       bad_code;
  logic       scan_lost;

  modport master (
    output seg, an,
    input  digit0, digit1, digit2, digit3, digit_valid, frame_valid, bad_code, scan_lost
  );

  modport slave (
    input  seg, an,
    output digit0, digit1, digit2, digit3, digit_valid, frame_valid, bad_code, scan_lost
  );
endinterface

// File: rtl/sevenseg_capture.sv
// Recovers the four hex digits shown on a multiplexed active-low seven-segment
// bus, with per-digit validity, frame completion, bad-pattern and scan-loss flags.
module sevenseg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               clr_n,
  sevenseg_capture_if.slave  bus
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES);
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [SCW-1:0] STABLE_ONE  = SCW'(1);
  localparam logic [TCW-1:0] TO_MAX      = TCW'(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TO_LAST     = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] TO_ONE      = TCW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  // Returns {legal, value}; input is the raw active-low gfedcba pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg_n);
    logic [6:0] lit;
    lit = ~seg_n;
    case (lit)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [3:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [1:0]       state_q, state_d;
  logic [10:0]      cand_q, cand_d;
  logic [SCW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [TCW-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       valid_q, valid_d;
  logic             frame_q, frame_d;
  logic             bad_q, bad_d;
  logic             lost_q, lost_d;

  logic [10:0]      cur;
  logic [3:0]       an_low;
  logic             an_legal;
  logic             capture;
  logic [1:0]       cap_idx;
  logic [4:0]       dec;

  always_comb begin
    seg_s1_d = bus.seg;
    seg_s2_d = seg_s1_q;
    an_s1_d  = bus.an;
    an_s2_d  = an_s1_q;
  end

  // Stability tracker: a pattern is captured once after STABLE_CYCLES identical samples.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    capture    = 1'b0;
    cur        = {an_s2_q, seg_s2_q};
    an_low     = ~an_s2_q;
    an_legal   = (an_low != '0) && ((an_low & (an_low - 4'd1)) == '0);

    if (!an_legal) begin
      state_d    = ST_IDLE;
      stab_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_TRACK;
          stab_cnt_d = STABLE_ONE;
          cand_d     = cur;
        end
        ST_TRACK: begin
          if (cur == cand_q) begin
            if (stab_cnt_q == STABLE_LAST) begin
              capture    = 1'b1;
              state_d    = ST_HELD;
              stab_cnt_d = STABLE_MAX;
            end else begin
              stab_cnt_d = stab_cnt_q + STABLE_ONE;
            end
          end else begin
            stab_cnt_d = STABLE_ONE;
            cand_d     = cur;
          end
        end
        ST_HELD: begin
          if (cur != cand_q) begin
            state_d    = ST_TRACK;
            stab_cnt_d = STABLE_ONE;
            cand_d     = cur;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          stab_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cap_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!cand_q[7 + i]) cap_idx = 2'(i);
    end
    dec = decode_seg(cand_q[6:0]);
  end

  // Capture results, frame tracking and scan-loss timeout.
  always_comb begin
    digit_d  = digit_q;
    valid_d  = valid_q;
    bad_d    = 1'b0;
    lost_d   = lost_q;
    to_cnt_d = to_cnt_q;
    frame_d  = (seen_q == 4'hF);
    seen_d   = (seen_q == 4'hF) ? '0 : seen_q;

    if (capture) begin
      seen_d   = seen_d | (4'b0001 << cap_idx);
      to_cnt_d = '0;
      lost_d   = 1'b0;
      if (dec[4]) begin
        digit_d[cap_idx] = dec[3:0];
        valid_d[cap_idx] = 1'b1;
      end else begin
        valid_d[cap_idx] = 1'b0;
        bad_d            = 1'b1;
      end
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_ONE;
      if (to_cnt_q == TO_LAST) begin
        lost_d  = 1'b1;
        valid_d = '0;
        seen_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      an_s1_q    <= '0;
      an_s2_q    <= '0;
      state_q    <= ST_IDLE;
      cand_q     <= '0;
      stab_cnt_q <= '0;
      to_cnt_q   <= '0;
      seen_q     <= '0;
      digit_q    <= '0;
      valid_q    <= '0;
      frame_q    <= 1'b0;
      bad_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      seg_s1_q   <= seg_s1_d;
      seg_s2_q   <= seg_s2_d;
      an_s1_q    <= an_s1_d;
      an_s2_q    <= an_s2_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      stab_cnt_q <= stab_cnt_d;
      to_cnt_q   <= to_cnt_d;
      seen_q     <= seen_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      bad_q      <= bad_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.digit0      = digit_q[0];
  assign bus.digit1      = digit_q[1];
  assign bus.digit2      = digit_q[2];
  assign bus.digit3      = digit_q[3];
  assign bus.digit_valid = valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.bad_code    = bad_q;
  assign bus.scan_lost   = lost_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Self-checking bench for sevenseg_capture: directed scenarios plus a randomized
// scan, compared against a run-length model of the display bus.
module tb_sevenseg_capture;

  localparam int S = 16;
  localparam int T = 1000;
  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  sevenseg_capture_if bus ();

  sevenseg_capture #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int mon_frames = 0, mon_bad = 0, mon_frame_edge = -1, mon_bad_edge = -1;
  always @(negedge clk) begin
    if (clr_n) begin
      if (bus.frame_valid) begin
        mon_frames     <= mon_frames + 1;
        mon_frame_edge <= cyc;
      end
      if (bus.bad_code) begin
        mon_bad      <= mon_bad + 1;
        mon_bad_edge <= cyc;
      end
    end
  end

  // Reference model: digits captured once per run of >= S identical samples.
  logic [3:0] m_digit [4];
  logic [3:0] m_valid, m_seen;
  logic       m_lost;
  int         m_last;
  int         exp_frames = 0, exp_bad = 0, m_frame_edge = -1, m_bad_edge = -1;
  logic       r_active, r_done;
  logic [3:0] r_an;
  logic [6:0] r_seg;
  int         r_start, r_end, r_len;

  function automatic bit legal_an(input logic [3:0] a);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) z++;
    return z == 1;
  endfunction

  function automatic logic [15:0] m_digits();
    return {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
  endfunction

  task automatic model_reset(input int now);
    for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
    m_valid  = 4'h0;
    m_seen   = 4'h0;
    m_lost   = 1'b0;
    m_last   = now;
    r_active = 1'b0;
    r_done   = 1'b0;
  endtask

  task automatic model_sync(input int now);
    if (!m_lost && now >= m_last + T) begin
      m_lost  = 1'b1;
      m_valid = 4'h0;
      m_seen  = 4'h0;
    end
  endtask

  task automatic model_capture(input int idx, input logic [6:0] s, input int ce);
    int val = -1;
    model_sync(ce - 1);
    for (int v = 0; v < 16; v++) if (PAT[v] == ~s) val = v;
    if (val >= 0) begin
      m_digit[idx] = 4'(val);
      m_valid[idx] = 1'b1;
    end else begin
      m_valid[idx] = 1'b0;
      exp_bad++;
      m_bad_edge = ce;
    end
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      exp_frames++;
      m_frame_edge = ce + 1;
      m_seen = 4'h0;
    end
    m_last = ce;
    m_lost = 1'b0;
  endtask

  task automatic model_run(input logic [3:0] a, input logic [6:0] s, input int start, input int n);
    int idx = 0;
    if (r_active && a == r_an && s == r_seg && start == r_end + 1) begin
      r_len += n;
    end else begin
      r_active = 1'b1;
      r_an = a;
      r_seg = s;
      r_start = start;
      r_len = n;
      r_done = 1'b0;
    end
    r_end = start + n - 1;
    if (legal_an(a) && !r_done && r_len >= S) begin
      r_done = 1'b1;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      model_capture(idx, s, r_start + S + 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_run(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an  = a;
    bus.seg = s;
    model_run(a, s, cyc + 1, n);
    repeat (n) step();
  endtask

  task automatic settle();
    drive_run(4'hF, 7'h7F, 4);
  endtask

  task automatic do_reset();
    clr_n   = 1'b0;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    clr_n = 1'b1;
    model_reset(cyc);
  endtask

  task automatic scan_basic();
    drive_run(4'b0111, 7'h79, 64);
    drive_run(4'b1011, 7'h24, 64);
    drive_run(4'b1101, 7'h30, 64);
    drive_run(4'b1110, 7'h19, 64);
    settle();
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    bus.an = 4'hF;
    bus.seg = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_digits: got %h expected 0000", {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
    end
    n_checks++;
    if (bus.digit_valid !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_valid: got %b expected 0000", bus.digit_valid);
    end
    n_checks++;
    if ({bus.frame_valid, bus.bad_code, bus.scan_lost} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000", {bus.frame_valid, bus.bad_code, bus.scan_lost});
    end
    do_reset();
  endtask

  task automatic test_basic_scan();
    do_reset();
    scan_basic();
    n_checks++;
    if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'h1234) begin
      n_errors++;
      $display("FAIL basic_digits: got %h expected 1234", {bus.digit3, bus.digit2, bus.digit1, bus.digit0});
    end
    n_checks++;
    if (bus.digit_valid !== m_valid || m_valid !== 4'hF) begin
      n_errors++;
      $display("FAIL basic_valid: got %b expected %b", bus.digit_valid, m_valid);
    end
    n_checks++;
    if (mon_frames !== exp_frames) begin
      n_errors++;
      $display("FAIL basic_frame_count: got %0d expected %0d", mon_frames, exp_frames);
    end
    n_checks++;
    if (mon_frame_edge !== m_frame_edge) begin
      n_errors++;
      $display("FAIL basic_frame_edge: got %0d expected %0d", mon_frame_edge, m_frame_edge);
    end
  endtask

  task automatic test_stable_boundary();
    int k;
    do_reset();
    drive_run(4'b1110, 7'h40, S - 1);
    drive_run(4'hF, 7'h40, 20);
    n_checks++;
    if (bus.digit_valid !== 4'h0 || bus.digit0 !== 4'h0) begin
      n_errors++;
      $display("FAIL short_hold: got valid %b digit0 %h expected 0000 0", bus.digit_valid, bus.digit0);
    end
    bus.an  = 4'b1110;
    bus.seg = 7'h40;
    k = cyc + 1;
    model_run(4'b1110, 7'h40, k, S);
    repeat (S) step();
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    model_run(4'hF, 7'h7F, cyc + 1, 3);
    step();
    n_checks++;
    if (bus.digit_valid[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_early: edge %0d valid0 got %b expected 0", cyc - k, bus.digit_valid[0]);
    end
    step();
    n_checks++;
    if (bus.digit_valid[0] !== 1'b1 || bus.digit0 !== 4'h0 || cyc !== k + S + 1) begin
      n_errors++;
      $display("FAIL latency_capture: got valid0 %b digit0 %h expected 1 0", bus.digit_valid[0], bus.digit0);
    end
    step();
    n_checks++;
    if (bus.digit_valid !== m_valid || m_digits() !== {bus.digit3, bus.digit2, bus.digit1, bus.digit0}) begin
      n_errors++;
      $display("FAIL boundary_model: got valid %b expected %b", bus.digit_valid, m_valid);
    end
  endtask

  task automatic test_bad_code();
    int bad0;
    do_reset();
    drive_run(4'b1110, ~7'h6D, 64);
    bad0 = mon_bad;
    drive_run(4'b1110, 7'h7F, 64);
    settle();
    n_checks++;
    if (mon_bad - bad0 !== 1 || mon_bad !== exp_bad) begin
      n_errors++;
      $display("FAIL bad_pulse_count: got %0d expected 1", mon_bad - bad0);
    end
    n_checks++;
    if (mon_bad_edge !== m_bad_edge) begin
      n_errors++;
      $display("FAIL bad_pulse_edge: got %0d expected %0d", mon_bad_edge, m_bad_edge);
    end
    n_checks++;
    if (bus.digit_valid[0] !== 1'b0 || bus.digit0 !== 4'h5) begin
      n_errors++;
      $display("FAIL bad_digit_hold: got valid0 %b digit0 %h expected 0 5", bus.digit_valid[0], bus.digit0);
    end
  endtask

  task automatic test_illegal_anode();
    int f0, b0;
    do_reset();
    f0 = mon_frames;
    b0 = mon_bad;
    drive_run(4'b1100, 7'h40, 64);
    drive_run(4'b1111, 7'h40, 64);
    n_checks++;
    if (bus.digit_valid !== 4'h0 || {bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'h0) begin
      n_errors++;
      $display("FAIL illegal_capture: got valid %b expected 0000", bus.digit_valid);
    end
    n_checks++;
    if (mon_frames !== f0 || mon_bad !== b0) begin
      n_errors++;
      $display("FAIL illegal_pulses: got frames %0d bad %0d expected %0d %0d", mon_frames, mon_bad, f0, b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    scan_basic();
    drive_run(4'hF, 7'h7F, m_last + T - 1 - cyc);
    model_sync(cyc);
    n_checks++;
    if (bus.scan_lost !== m_lost || bus.digit_valid !== m_valid || m_lost !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_early: got lost %b valid %b expected 0 1111", bus.scan_lost, bus.digit_valid);
    end
    drive_run(4'hF, 7'h7F, 1);
    model_sync(cyc);
    n_checks++;
    if (bus.scan_lost !== m_lost || bus.digit_valid !== m_valid || m_lost !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_fire: got lost %b valid %b expected 1 0000", bus.scan_lost, bus.digit_valid);
    end
    drive_run(4'b1110, ~7'h07, 64);
    settle();
    model_sync(cyc);
    n_checks++;
    if (bus.scan_lost !== 1'b0 || bus.digit_valid !== 4'b0001 || bus.digit0 !== 4'h7) begin
      n_errors++;
      $display("FAIL timeout_resume: got lost %b valid %b digit0 %h expected 0 0001 7", bus.scan_lost, bus.digit_valid, bus.digit0);
    end
  endtask

  task automatic test_reset_mid_track();
    int c2;
    do_reset();
    scan_basic();
    bus.an  = 4'b1011;
    bus.seg = ~7'h6F;
    repeat (12) step();
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== 16'h0 || bus.digit_valid !== 4'h0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got %h valid %b expected 0000 0000", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, bus.digit_valid);
    end
    n_checks++;
    if ({bus.frame_valid, bus.bad_code, bus.scan_lost} !== 3'b000) begin
      n_errors++;
      $display("FAIL midreset_flags: got %b expected 000", {bus.frame_valid, bus.bad_code, bus.scan_lost});
    end
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    c2 = cyc;
    model_reset(c2);
    model_run(4'b1011, ~7'h6F, c2 + 1, S + 2);
    repeat (S + 1) step();
    n_checks++;
    if (bus.digit_valid !== 4'h0 || bus.digit2 !== 4'h0) begin
      n_errors++;
      $display("FAIL midreset_early: got valid %b digit2 %h expected 0000 0", bus.digit_valid, bus.digit2);
    end
    step();
    n_checks++;
    if (bus.digit_valid !== m_valid || bus.digit2 !== m_digit[2] || m_digit[2] !== 4'h9) begin
      n_errors++;
      $display("FAIL midreset_capture: got valid %b digit2 %h expected %b %h", bus.digit_valid, bus.digit2, m_valid, m_digit[2]);
    end
    settle();
  endtask

  task automatic test_random_scan();
    logic [3:0] a;
    logic [6:0] s;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      for (int d = 3; d >= 0; d--) begin
        if ($urandom_range(0, 3) == 0) begin
          a = ~(4'b0001 << $urandom_range(0, 3));
          s = ~PAT[$urandom_range(0, 15)];
          drive_run(a, s, $urandom_range(1, S - 1));
        end
        a = ~(4'b0001 << d);
        if ($urandom_range(0, 7) == 0) s = 7'($urandom_range(0, 127));
        else s = ~PAT[$urandom_range(0, 15)];
        drive_run(a, s, $urandom_range(S + 5, S + 30));
      end
      settle();
      model_sync(cyc);
      n_checks++;
      if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== m_digits()) begin
        n_errors++;
        $display("FAIL rand_digits[%0d]: got %h expected %h", f, {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, m_digits());
      end
      n_checks++;
      if (bus.digit_valid !== m_valid || bus.scan_lost !== m_lost) begin
        n_errors++;
        $display("FAIL rand_valid[%0d]: got %b/%b expected %b/%b", f, bus.digit_valid, bus.scan_lost, m_valid, m_lost);
      end
      n_checks++;
      if (mon_frames !== exp_frames || mon_bad !== exp_bad) begin
        n_errors++;
        $display("FAIL rand_pulses[%0d]: got frames %0d bad %0d expected %0d %0d", f, mon_frames, mon_bad, exp_frames, exp_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_stable_boundary();
    test_bad_code();
    test_illegal_anode();
    test_timeout();
    test_reset_mid_track();
    test_random_scan();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
